// File: rtl/nanov_spi_mem_ctrl_if.sv
// nanov_spi_mem_ctrl_if: core-side fetch/load/store bus of nanov_spi_mem_ctrl
interface nanov_spi_mem_ctrl_if #(
    parameter int ADDR_BITS = 24
);
    logic                 start_instr;
    logic                 start_read;
    logic                 start_write;
    logic [ADDR_BITS-1:0] addr;
    logic [1:0]           size;
    logic [31:0]          wdata;
    logic                 stop;
    logic                 busy;
    logic [31:0]          instr_out;
    logic                 instr_ready;
    logic [31:0]          rdata;
    logic                 rdata_ready;
    logic                 write_done;

    modport master (
        output start_instr, start_read, start_write, addr, size, wdata, stop,
        input  busy, instr_out, instr_ready, rdata, rdata_ready, write_done
    );

    modport slave (
        input  start_instr, start_read, start_write, addr, size, wdata, stop,
        output busy, instr_out, instr_ready, rdata, rdata_ready, write_done
    );
endinterface

// File: rtl/nanov_spi_mem_ctrl.sv
// nanov_spi_mem_ctrl: SPI mode-0 master turning nanoV fetch/load/store requests
// into READ (0x03) / WRITE (0x02) transactions, words little-endian.
module nanov_spi_mem_ctrl #(
    parameter int ADDR_BITS = 24
) (
    input  logic                clk,
    input  logic                rst,
    nanov_spi_mem_ctrl_if.slave bus,
    output logic                spi_cs_n,
    output logic                spi_sck,
    output logic                spi_mosi,
    input  logic                spi_miso
);
    localparam int TW = 8 + ADDR_BITS + 32;
    localparam logic [2:0] IDLE = 3'd0, CMD = 3'd1, ADDR = 3'd2, DATA = 3'd3, DESEL = 3'd4;
    localparam logic [1:0] M_INSTR = 2'd0, M_READ = 2'd1, M_WRITE = 2'd2;

    logic [2:0]    state;
    logic [1:0]    mode;
    logic [1:0]    sz;
    logic [1:0]    dcnt;
    logic          phase;
    logic [5:0]    cnt;
    logic [5:0]    data_bits;
    logic [TW-1:0] tx;
    logic [30:0]   rx;
    logic [31:0]   rx_next;
    logic [31:0]   sw;
    logic [31:0]   wswap;
    logic [31:0]   rd_word;
    logic          any_start;

    // rx collects bytes in arrival order, so a byte swap yields the little-endian word
    assign rx_next   = {rx, spi_miso};
    assign sw        = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};
    assign wswap     = {bus.wdata[7:0], bus.wdata[15:8], bus.wdata[23:16], bus.wdata[31:24]};
    assign rd_word   = sz[1] ? sw : sz[0] ? {16'd0, sw[31:16]} : {24'd0, sw[31:24]};
    assign data_bits = (mode == M_INSTR || sz[1]) ? 6'd31 : sz[0] ? 6'd15 : 6'd7;
    assign any_start = bus.start_write | bus.start_read | bus.start_instr;
    // tx is cleared outside a transmit window, which keeps mosi low there
    assign spi_mosi  = tx[TW-1];
    assign bus.busy  = state != IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            mode            <= M_INSTR;
            sz              <= 2'd0;
            dcnt            <= 2'd0;
            phase           <= 1'b0;
            cnt             <= 6'd0;
            tx              <= '0;
            rx              <= '0;
            spi_cs_n        <= 1'b1;
            spi_sck         <= 1'b0;
            bus.instr_out   <= '0;
            bus.instr_ready <= 1'b0;
            bus.rdata       <= '0;
            bus.rdata_ready <= 1'b0;
            bus.write_done  <= 1'b0;
        end else begin
            bus.instr_ready <= 1'b0;
            bus.rdata_ready <= 1'b0;
            bus.write_done  <= 1'b0;
            if (state == IDLE) begin
                if (any_start) begin
                    state    <= CMD;
                    mode     <= bus.start_write ? M_WRITE : bus.start_read ? M_READ : M_INSTR;
                    sz       <= bus.size;
                    tx       <= {bus.start_write ? 8'h02 : 8'h03, bus.addr, bus.start_write ? wswap : 32'd0};
                    cnt      <= 6'd7;
                    phase    <= 1'b0;
                    spi_cs_n <= 1'b0;
                end
            end else if (state == DESEL) begin
                spi_cs_n <= 1'b1;
                dcnt     <= dcnt - 2'd1;
                if (dcnt == 2'd1)
                    state <= IDLE;
            end else if (mode == M_INSTR && bus.stop) begin
                state    <= DESEL;
                dcnt     <= 2'd2;
                spi_cs_n <= 1'b1;
                spi_sck  <= 1'b0;
                tx       <= '0;
            end else if (!phase) begin
                spi_sck <= 1'b1;
                phase   <= 1'b1;
            end else begin
                spi_sck <= 1'b0;
                phase   <= 1'b0;
                tx      <= tx << 1;
                rx      <= rx_next[30:0];
                cnt     <= cnt - 6'd1;
                if (cnt == 6'd0) begin
                    if (state == CMD) begin
                        state <= ADDR;
                        cnt   <= 6'(ADDR_BITS - 1);
                    end else if (state == ADDR) begin
                        state <= DATA;
                        cnt   <= data_bits;
                    end else if (mode == M_INSTR) begin
                        bus.instr_out   <= sw;
                        bus.instr_ready <= 1'b1;
                        cnt             <= 6'd31;
                    end else begin
                        // one extra DESEL count keeps cs_n low through the pulse cycle
                        state           <= DESEL;
                        dcnt            <= 2'd3;
                        tx              <= '0;
                        bus.rdata_ready <= mode == M_READ;
                        bus.write_done  <= mode != M_READ;
                        if (mode == M_READ)
                            bus.rdata <= rd_word;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_nanov_spi_mem_ctrl.sv
// tb_nanov_spi_mem_ctrl: SPI memory device model plus scoreboard for nanov_spi_mem_ctrl
module tb_nanov_spi_mem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_cs_n, spi_sck, spi_mosi;
    logic spi_miso = 1'b0;

    nanov_spi_mem_ctrl_if #(.ADDR_BITS(24)) bus();

    nanov_spi_mem_ctrl #(.ADDR_BITS(24)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .spi_cs_n(spi_cs_n),
        .spi_sck(spi_sck),
        .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          kind;
        logic [31:0] data;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    logic [7:0]  mem [0:65535];
    int          n = 0;
    logic [7:0]  cmd_cap = 8'd0;
    logic [23:0] addr_cap = 24'd0;
    logic [7:0]  wbyte = 8'd0;
    logic [7:0]  rd_b;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] le(input int a, input int nb);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < nb; j++) w[8*j +: 8] = mem[16'(a + j)];
        return w;
    endfunction

    // SPI memory device: command, 24-bit address, then auto-incrementing data
    always @(posedge spi_cs_n) begin
        n = 0;
        spi_miso = 1'b0;
    end

    always @(posedge spi_sck) if (!spi_cs_n) begin
        if (n < 8) cmd_cap = {cmd_cap[6:0], spi_mosi};
        else if (n < 32) addr_cap = {addr_cap[22:0], spi_mosi};
        else if (cmd_cap == 8'h02) begin
            wbyte = {wbyte[6:0], spi_mosi};
            if ((n - 32) % 8 == 7) mem[16'(int'(addr_cap) + (n - 32) / 8)] = wbyte;
        end else begin
            checks++;
            if (spi_mosi) begin
                errors++;
                $display("FAIL mosi_rx: mosi=1 in receive phase at bit %0d", n);
            end
        end
        n++;
    end

    always @(negedge spi_sck) begin
        #1;
        if (!spi_cs_n && n >= 32 && cmd_cap == 8'h03) begin
            rd_b = mem[16'(int'(addr_cap) + (n - 32) / 8)];
            spi_miso = rd_b[7 - (n - 32) % 8];
        end
    end

    // monitor: every pulse pops one expectation
    always @(negedge clk) if (!rst) begin
        exp_t e;
        if (spi_cs_n) begin
            checks++;
            if (spi_mosi) begin
                errors++;
                $display("FAIL mosi_idle: mosi=1 while cs_n=1 at cycle %0d", cyc);
            end
        end
        if (bus.instr_ready || bus.rdata_ready || bus.write_done) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pulse_unexpected: ir=%b rr=%b wd=%b with nothing expected at cycle %0d",
                         bus.instr_ready, bus.rdata_ready, bus.write_done, cyc);
            end else begin
                e = sb.pop_front();
                chk("pulse_kind", bus.write_done ? 2 : bus.rdata_ready ? 1 : 0, e.kind);
                chk("pulse_data", e.kind == 2 ? 0 : e.kind == 1 ? bus.rdata : bus.instr_out, e.data);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_idle(input int c0, input int n_low, input string name);
        int hi = 0;
        bit done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (!bus.busy) done = 1;
            else begin
                if (spi_cs_n) hi++;
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: busy still high after 400 cycles", name);
        end else begin
            chk({name, "_idle_cyc"}, cyc - c0 + 1, n_low);
            chk({name, "_desel"}, hi, 2);
        end
    endtask

    task automatic run_instr(input logic [23:0] a, input int s, input string name);
        int c0;
        @(negedge clk);
        bus.addr = a;
        bus.size = 2'($urandom);
        bus.start_instr = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.start_instr = 1'b0;
        for (int k = 0; 129 + 64 * k <= s; k++)
            sb.push_back('{0, le(int'(a) + 4 * k, 4), c0 + 128 + 64 * k});
        repeat (s - 1) @(posedge clk);
        #1;
        bus.stop = 1'b1;
        @(posedge clk);
        #1;
        bus.stop = 1'b0;
        chk({name, "_cs_off"}, 32'(spi_cs_n), 1);
        chk({name, "_sck_off"}, 32'(spi_sck), 0);
        wait_idle(c0, s + 3, name);
        chk({name, "_cmd"}, 32'(cmd_cap), 32'h03);
        chk({name, "_addr"}, 32'(addr_cap), 32'(a));
    endtask

    task automatic run_rw(input bit wr, input logic [23:0] a, input logic [1:0] sz,
                          input logic [31:0] wd, input bit dup, input string name);
        int c0, nb;
        logic [31:0] e;
        logic [7:0] after;
        nb = sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
        e = le(int'(a), nb);
        after = mem[16'(int'(a) + nb)];
        @(negedge clk);
        bus.addr = a;
        bus.size = sz;
        bus.wdata = wd;
        bus.start_write = wr;
        bus.start_read = !wr || dup;
        bus.start_instr = dup;
        @(posedge clk);
        #1;
        c0 = cyc;
        bus.start_write = 1'b0;
        bus.start_read = 1'b0;
        bus.start_instr = 1'b0;
        sb.push_back('{wr ? 2 : 1, wr ? 32'h0 : e, c0 + 2 * (32 + 8 * nb)});
        repeat (4) @(posedge clk);
        #1;
        bus.start_read = 1'b1;
        bus.start_instr = 1'b1;
        bus.addr = 24'($urandom);
        bus.size = 2'($urandom);
        bus.wdata = $urandom;
        @(posedge clk);
        #1;
        bus.start_read = 1'b0;
        bus.start_instr = 1'b0;
        wait_idle(c0, 2 * (32 + 8 * nb) + 4, name);
        chk({name, "_cmd"}, 32'(cmd_cap), wr ? 32'h02 : 32'h03);
        chk({name, "_addr"}, 32'(addr_cap), 32'(a));
        if (wr) begin
            for (int j = 0; j < nb; j++)
                chk({name, "_mem"}, 32'(mem[16'(int'(a) + j)]), 32'(wd[8*j +: 8]));
            chk({name, "_mem_past"}, 32'(mem[16'(int'(a) + nb)]), 32'(after));
        end
    endtask

    task automatic put_word(input int a, input logic [31:0] w);
        for (int j = 0; j < 4; j++) mem[16'(a + j)] = w[8*j +: 8];
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kd;
        logic [23:0] ra;
        bus.start_instr = 1'b0;
        bus.start_read = 1'b0;
        bus.start_write = 1'b0;
        bus.stop = 1'b0;
        bus.addr = '0;
        bus.size = 2'd0;
        bus.wdata = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        put_word(32'h100, 32'h00500093);
        put_word(32'h104, 32'h00A00113);
        mem[16'h1003] = 8'hF5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cs_n", 32'(spi_cs_n), 1);
        chk("rst_sck", 32'(spi_sck), 0);
        chk("rst_mosi", 32'(spi_mosi), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pulses", {29'd0, bus.instr_ready, bus.rdata_ready, bus.write_done}, 0);
        chk("rst_instr_out", bus.instr_out, 0);
        chk("rst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        run_instr(24'h000100, 200, "instr");
        run_rw(1'b0, 24'h001003, 2'd0, 32'h0, 1'b0, "rd_byte");
        run_rw(1'b1, 24'h000200, 2'd1, 32'hDEADBEEF, 1'b0, "wr_half");
        run_instr(24'h000400, 100, "stop100");
        run_instr(24'h000400, 128, "stop128");
        run_rw(1'b1, 24'h000300, 2'd2, $urandom, 1'b1, "wr_prio");
        run_rw(1'b0, 24'h000500, 2'd3, 32'h0, 1'b1, "rd_prio");
        @(negedge clk);
        bus.addr = 24'h000100;
        bus.start_instr = 1'b1;
        @(posedge clk);
        #1;
        bus.start_instr = 1'b0;
        repeat (30) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("arst_cs_n", 32'(spi_cs_n), 1);
        chk("arst_sck", 32'(spi_sck), 0);
        chk("arst_busy", 32'(bus.busy), 0);
        chk("arst_instr_out", bus.instr_out, 0);
        chk("arst_rdata", bus.rdata, 0);
        @(negedge clk);
        rst = 1'b0;
        run_instr(24'h000100, 150, "post_rst");
        for (int t = 0; t < 24; t++) begin
            kd = int'($urandom_range(0, 2));
            ra = 24'($urandom_range(0, 32'hFF00));
            if (kd == 0) run_instr(ra, int'($urandom_range(20, 330)), "rnd_instr");
            else run_rw(kd == 2, ra, 2'($urandom), $urandom, $urandom_range(0, 1) == 1,
                        kd == 2 ? "rnd_write" : "rnd_read");
        end
        repeat (5) @(posedge clk);
        #1;
        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
